// File: rtl/hci_hwpe_strided_source.sv
`default_nettype none
// ============================================================================
// Module   : hci_hwpe_strided_source
// Purpose  : 2-D strided TCDM read engine feeding an HWPE valid/ready stream
//            through a credit-controlled response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module hci_hwpe_strided_source #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 128,
  parameter int unsigned LW         = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic [AW-1:0]   base_addr_i,
  input  logic [AW-1:0]   d0_stride_i,
  input  logic [LW-1:0]   d0_len_i,
  input  logic [AW-1:0]   d1_stride_i,
  input  logic [LW-1:0]   d1_len_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            tcdm_req_o,
  input  logic            tcdm_gnt_i,
  output logic [AW-1:0]   tcdm_add_o,
  output logic            tcdm_wen_o,
  output logic [DW/8-1:0] tcdm_be_o,
  output logic [DW-1:0]   tcdm_data_o,
  input  logic [DW-1:0]   tcdm_r_data_i,
  input  logic            tcdm_r_valid_i,
  output logic            stream_valid_o,
  input  logic            stream_ready_i,
  output logic [DW-1:0]   stream_data_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   c_DEPTH = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_FULL  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] c_LAST  = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state, w_state_next;
  logic            r_done, w_done_next;
  logic [AW-1:0]   r_d0_stride, r_d1_stride;
  logic [LW-1:0]   r_d0_len, r_d1_len;
  logic [LW-1:0]   r_i0, r_i1;
  logic [AW-1:0]   r_addr, r_row_addr;
  logic            r_outstanding;

  logic [DW-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_req, w_hs, w_last0, w_last1, w_zero_len;
  logic            w_push, w_pop, w_empty, w_full;
  logic [CW:0]     w_used;
  logic [AW-1:0]   w_next_row;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_FULL);
  assign w_used     = {1'b0, r_count} + {{CW{1'b0}}, r_outstanding};
  // Credits cover both stored entries and the one response still in flight.
  assign w_req      = (r_state == S_RUN) && (w_used < c_DEPTH);
  assign w_hs       = w_req & tcdm_gnt_i;
  assign w_last0    = (r_i0 == r_d0_len - LW'(1));
  assign w_last1    = (r_i1 == r_d1_len - LW'(1));
  assign w_zero_len = (d0_len_i == '0) || (d1_len_i == '0);
  assign w_next_row = r_row_addr + r_d1_stride;
  // Responses are only accepted for a grant issued since the last reset/clear.
  assign w_push     = tcdm_r_valid_i & r_outstanding;
  assign w_pop      = ~w_empty & stream_ready_i;

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_zero_len) w_done_next = 1'b1;
          else            w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_hs && w_last0 && w_last1) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_empty && !r_outstanding) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_d0_stride   <= '0;
      r_d1_stride   <= '0;
      r_d0_len      <= '0;
      r_d1_len      <= '0;
      r_i0          <= '0;
      r_i1          <= '0;
      r_addr        <= '0;
      r_row_addr    <= '0;
      r_outstanding <= 1'b0;
    end else begin
      r_outstanding <= w_hs;
      if ((r_state == S_IDLE) && start_i) begin
        r_d0_stride <= d0_stride_i;
        r_d1_stride <= d1_stride_i;
        r_d0_len    <= d0_len_i;
        r_d1_len    <= d1_len_i;
        r_addr      <= base_addr_i;
        r_row_addr  <= base_addr_i;
        r_i0        <= '0;
        r_i1        <= '0;
      end else if (w_hs) begin
        if (w_last0) begin
          r_i0       <= '0;
          r_i1       <= r_i1 + LW'(1);
          r_row_addr <= w_next_row;
          r_addr     <= w_next_row;
        end else begin
          r_i0   <= r_i0 + LW'(1);
          r_addr <= r_addr + r_d0_stride;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= tcdm_r_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i) assert (!(w_push && w_full));
  end
`endif

  assign busy_o         = (r_state != S_IDLE);
  assign done_o         = r_done;
  assign tcdm_req_o     = w_req;
  assign tcdm_add_o     = r_addr;
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = '1;
  assign tcdm_data_o    = '0;
  assign stream_valid_o = ~w_empty;
  assign stream_data_o  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_hci_hwpe_strided_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_hci_hwpe_strided_source
// Purpose  : Directed self-checking bench for hci_hwpe_strided_source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hci_hwpe_strided_source;

  localparam int AW = 32;
  localparam int DW = 128;
  localparam int LW = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            clear_i = 1'b0;
  logic            start_i = 1'b0;
  logic [AW-1:0]   base_addr_i = '0;
  logic [AW-1:0]   d0_stride_i = '0;
  logic [LW-1:0]   d0_len_i = '0;
  logic [AW-1:0]   d1_stride_i = '0;
  logic [LW-1:0]   d1_len_i = '0;
  logic            busy_o, done_o, tcdm_req_o, tcdm_wen_o, stream_valid_o;
  logic            tcdm_gnt_i = 1'b1;
  logic [AW-1:0]   tcdm_add_o;
  logic [DW/8-1:0] tcdm_be_o;
  logic [DW-1:0]   tcdm_data_o, stream_data_o;
  logic [DW-1:0]   tcdm_r_data_i = '0;
  logic            tcdm_r_valid_i = 1'b0;
  logic            stream_ready_i = 1'b1;

  hci_hwpe_strided_source dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .d0_stride_i(d0_stride_i), .d0_len_i(d0_len_i),
    .d1_stride_i(d1_stride_i), .d1_len_i(d1_len_i),
    .busy_o(busy_o), .done_o(done_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .stream_data_o(stream_data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] beat_log[$];
  logic [AW-1:0] exp_q[$];
  int done_cnt, done_cyc, last_beat_cyc, gnt_cnt, first_hs, last_hs, hold_viol;
  logic gnt_alt = 1'b0;
  logic prev_pend = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'd1};
  endfunction

  // One clock: log what happened in the current cycle, advance, then model TCDM.
  task automatic tick();
    logic hs;
    logic [AW-1:0] a;
    hs = tcdm_req_o & tcdm_gnt_i;
    a  = tcdm_add_o;
    if (prev_pend && (!tcdm_req_o || tcdm_add_o != prev_addr)) hold_viol++;
    prev_pend = tcdm_req_o & ~tcdm_gnt_i;
    prev_addr = tcdm_add_o;
    if (hs) begin
      if (addr_log.size() == 0) first_hs = cyc;
      last_hs = cyc;
      addr_log.push_back(a);
      gnt_cnt++;
    end
    if (stream_valid_o & stream_ready_i) begin
      beat_log.push_back(stream_data_o);
      last_beat_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    tcdm_r_valid_i = hs;
    tcdm_r_data_i  = hs ? mem_data(a) : '0;
    if (gnt_alt) tcdm_gnt_i = ~tcdm_gnt_i;
  endtask

  task automatic clear_logs();
    addr_log.delete();
    beat_log.delete();
    done_cnt = 0; gnt_cnt = 0; hold_viol = 0;
    first_hs = -1; last_hs = -1; done_cyc = -1; last_beat_cyc = -1;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] s0,
                           input logic [LW-1:0] l0, input logic [AW-1:0] s1,
                           input logic [LW-1:0] l1);
    clear_logs();
    base_addr_i = base; d0_stride_i = s0; d0_len_i = l0;
    d1_stride_i = s1;   d1_len_i = l1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 300 && done_cnt == 0; k++) tick();
    chk({tag, "_done_seen"}, 128'(done_cnt > 0), 128'(1));
    repeat (3) tick();
    chk({tag, "_done_once"}, 128'(done_cnt), 128'(1));
    chk({tag, "_busy_end"}, 128'(busy_o), 128'(0));
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_naddr"}, 128'(addr_log.size()), 128'(exp_q.size()));
    chk({tag, "_nbeat"}, 128'(beat_log.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < addr_log.size()) chk($sformatf("%s_addr%0d", tag, i), 128'(addr_log[i]), 128'(exp_q[i]));
      if (i < beat_log.size()) chk($sformatf("%s_beat%0d", tag, i), beat_log[i], mem_data(exp_q[i]));
    end
  endtask

  task automatic load_t1_exp();
    exp_q = '{32'h1000, 32'h1010, 32'h1020, 32'h1030,
              32'h1100, 32'h1110, 32'h1120, 32'h1130};
  endtask

  initial begin
    clear_logs();
    // Reset state
    rst_i = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_done", 128'(done_o), 128'(0));
    chk("rst_req", 128'(tcdm_req_o), 128'(0));
    chk("rst_add", 128'(tcdm_add_o), 128'(0));
    chk("rst_valid", 128'(stream_valid_o), 128'(0));
    chk("rst_data", stream_data_o, 128'(0));
    chk("rst_wen", 128'(tcdm_wen_o), 128'(1));
    chk("rst_be", 128'(tcdm_be_o), 128'(16'hFFFF));
    rst_i = 1'b0;
    tick();

    // 1: basic 4x2 job, gnt=1, ready=1
    load_t1_exp();
    start_job(32'h1000, 32'd16, 16'd4, 32'h100, 16'd2);
    wait_done("t1");
    check_logs("t1");
    chk("t1_consecutive", 128'(last_hs - first_hs), 128'(7));
    chk("t1_done_lat", 128'(done_cyc - last_beat_cyc), 128'(2));

    // 2: gnt low on alternate cycles
    tcdm_gnt_i = 1'b0;
    gnt_alt = 1'b1;
    start_job(32'h1000, 32'd16, 16'd4, 32'h100, 16'd2);
    wait_done("t2");
    check_logs("t2");
    chk("t2_hold", 128'(hold_viol), 128'(0));
    gnt_alt = 1'b0;
    tcdm_gnt_i = 1'b1;

    // 3: back-pressure bounded by FIFO credits
    stream_ready_i = 1'b0;
    start_job(32'h1000, 32'd16, 16'd4, 32'h100, 16'd2);
    repeat (12) tick();
    chk("t3_grants", 128'(gnt_cnt), 128'(4));
    chk("t3_req_off", 128'(tcdm_req_o), 128'(0));
    chk("t3_valid", 128'(stream_valid_o), 128'(1));
    chk("t3_head", stream_data_o, mem_data(32'h1000));
    stream_ready_i = 1'b1;
    tick();
    stream_ready_i = 1'b0;
    repeat (6) tick();
    chk("t3_grants_1free", 128'(gnt_cnt), 128'(5));
    chk("t3_req_off2", 128'(tcdm_req_o), 128'(0));
    stream_ready_i = 1'b1;
    wait_done("t3");
    check_logs("t3");

    // 4a: zero-length job
    start_job(32'h2000, 32'd16, 16'd0, 32'h100, 16'd3);
    chk("t4_done", 128'(done_o), 128'(1));
    chk("t4_busy", 128'(busy_o), 128'(0));
    chk("t4_req", 128'(tcdm_req_o), 128'(0));
    tick();
    chk("t4_done_pulse", 128'(done_o), 128'(0));
    repeat (4) tick();
    chk("t4_no_grants", 128'(gnt_cnt), 128'(0));
    chk("t4_busy_after", 128'(busy_o), 128'(0));

    // 4b: start during RUN is ignored
    start_job(32'h1000, 32'd16, 16'd4, 32'h100, 16'd2);
    tick(); tick();
    base_addr_i = 32'h5000; d0_len_i = 16'd1; d1_len_i = 16'd1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done("t4b");
    check_logs("t4b");

    // 5: negative inner stride wraps modulo 2^AW
    exp_q = '{32'h0000_0008, 32'hFFFF_FFF8, 32'hFFFF_FFE8};
    start_job(32'h8, 32'hFFFF_FFF0, 16'd3, 32'h0, 16'd1);
    wait_done("t5");
    check_logs("t5");

    // 6: reset in the cycle of the 3rd grant; its response arrives after reset
    start_job(32'h1000, 32'd16, 16'd4, 32'h100, 16'd2);
    for (int k = 0; k < 50 && !(gnt_cnt == 2 && tcdm_req_o && tcdm_gnt_i); k++) tick();
    chk("t6_reached", 128'(gnt_cnt == 2 && tcdm_req_o && tcdm_gnt_i), 128'(1));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_req", 128'(tcdm_req_o), 128'(0));
    chk("t6_valid", 128'(stream_valid_o), 128'(0));
    chk("t6_busy", 128'(busy_o), 128'(0));
    chk("t6_rvalid_present", 128'(tcdm_r_valid_i), 128'(1));
    tick();
    chk("t6_dropped", 128'(stream_valid_o), 128'(0));
    tick();
    load_t1_exp();
    start_job(32'h1000, 32'd16, 16'd4, 32'h100, 16'd2);
    wait_done("t6");
    check_logs("t6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hci_hwpe_strided_source.md
Name: hci_hwpe_strided_source

Overview:
- 2-D strided read engine placed directly upstream of the HWPE port of the TCDM heterogeneous interconnect.
- On a start pulse it generates wide TCDM read requests (req/gnt) over a base/stride/length pattern.
- It collects the fixed-latency responses in a credit-controlled FIFO and presents them as a valid/ready stream to the HWPE datapath.

Parameters:
- AW, 32, address width (byte address).
- DW, 128, data width; matches the wide HWPE port.
- LW, 16, width of each length field.
- FIFO_DEPTH, 4, response FIFO entries (≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous soft clear; same effect as reset.
- start_i  in  1  single-cycle start pulse.
- base_addr_i  in  AW  first byte address.
- d0_stride_i  in  AW  inner stride in bytes; two's complement.
- d0_len_i  in  LW  inner element count.
- d1_stride_i  in  AW  outer stride in bytes; two's complement.
- d1_len_i  in  LW  outer row count.
- busy_o  out  1  high while not IDLE.
- done_o  out  1  one-cycle pulse at job end.
- tcdm_req_o  out  1  request valid.
- tcdm_gnt_i  in  1  request grant.
- tcdm_add_o  out  AW  request address.
- tcdm_wen_o  out  1  always 1 (read).
- tcdm_be_o  out  DW/8  always all-ones.
- tcdm_data_o  out  DW  always 0.
- tcdm_r_data_i  in  DW  response data.
- tcdm_r_valid_i  in  1  response valid; arrives exactly 1 cycle after the gnt.
- stream_valid_o  out  1  output data valid.
- stream_ready_i  in  1  downstream ready.
- stream_data_o  out  DW  output data.

Behaviour:
- Reset/clear:
  - Outputs after reset/clear: busy_o=0, done_o=0, tcdm_req_o=0, tcdm_add_o=0, stream_valid_o=0, stream_data_o=0.
  - Reset/clear sets the FSM to IDLE, empties the FIFO and zeroes all counters.
  - Either is honoured in any state, mid-job included.
  - A tcdm_r_valid_i arriving in the cycle after reset/clear is discarded.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - start_i latches every config input.
  - If d0_len_i==0 or d1_len_i==0: stay in IDLE, pulse done_o next cycle, issue no request.
  - Otherwise go to RUN next cycle.
  - start_i in RUN or DRAIN is ignored.
- RUN:
  - tcdm_req_o = (fifo_count + outstanding) < FIFO_DEPTH.
  - outstanding is 1 in the cycle after a grant, else 0.
  - Address on the first request = base.
  - On every handshake (req & gnt): i0 increments and addr += d0_stride.
  - When i0 reaches d0_len-1: i0 wraps to 0, i1 increments, and the row-start address advances by d1_stride. The next addr = new row start.
  - All address arithmetic is modulo 2^AW.
  - Once req is raised, tcdm_add_o is stable until gnt; req is never withdrawn before gnt.
  - The last handshake (i0=d0_len-1, i1=d1_len-1) moves the FSM to DRAIN; req=0 from the next cycle.
- DRAIN: when the FIFO is empty and outstanding=0, return to IDLE and pulse done_o in the same cycle. busy_o falls the next cycle.
- FIFO:
  - tcdm_r_valid_i pushes tcdm_r_data_i.
  - The stream side pops on stream_valid_o & stream_ready_i.
  - Push and pop in the same cycle are both allowed.
  - The credit rule guarantees no push when full. Overflow is an assertion failure.
  - stream_data_o comes from the FIFO head. stream_valid_o = !empty. Data is stable while valid & !ready.
- Latency: gnt at cycle t, r_valid at t+1, stream_valid_o at t+2 (registered FIFO output). Sustained throughput is 1 element/cycle when gnt=1 and ready=1.
- Total responses per job = d0_len*d1_len. Elements come out in issue order.

Test Plan:
1. base=0x1000, d0_stride=16, d0_len=4, d1_stride=0x100, d1_len=2, gnt=1, ready=1 → addresses 0x1000,0x1010,0x1020,0x1030,0x1100,0x1110,0x1120,0x1130 on consecutive cycles; 8 stream beats in order; done_o pulses exactly once, 2 cycles after the last beat's handshake.
2. Same job with gnt low on alternate cycles → tcdm_add_o held stable while req&!gnt; same address sequence; no duplicate or missing beat.
3. FIFO_DEPTH=4, ready=0 → exactly 4 grants, then req=0; raise ready → one further request per freed entry; no overflow assertion fires.
4. d0_len=0, start → no tcdm_req_o, done_o=1 one cycle later, busy_o stays 0. Second case: start asserted in RUN → job unchanged, no extra requests.
5. d0_stride=-16 (0xFFFFFFF0), base=0x8, d0_len=3, d1_len=1 → addresses 0x8, 0xFFFFFFF8, 0xFFFFFFE8.
6. rst_i asserted mid-RUN after 3 grants → next cycle req=0, stream_valid_o=0, busy_o=0; the pending r_valid is dropped. A new start runs a full job correctly.
